// File: rtl/mpy_pkg.sv
// mpy_pkg: shared widths, default settle depth and FSM states for mpy_ctrl
package mpy_pkg;
  localparam int OPW = 4;
  localparam int PW = 8;
  localparam int ACCW = 12;
  localparam int SETTLE_DEF = 12;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DONE} state_e;
endpackage

// File: rtl/settle_cnt.sv
// settle_cnt: loadable down-counter with enable and zero flag
module settle_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/mpy_ctrl.sv
// mpy_ctrl: operand sequencer and product/accumulator capture around the MPY array multiplier
module mpy_ctrl import mpy_pkg::*; #(
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  a_in,
  input  logic [OPW-1:0]  b_in,
  output logic [OPW-1:0]  mpy_a,
  output logic [OPW-1:0]  mpy_b,
  input  logic [PW-1:0]   mpy_p,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PW-1:0]   prod,
  output logic [ACCW-1:0] acc,
  input  logic            acc_clr
);
  state_e state_q, state_d;
  logic [OPW-1:0] a_q, a_d, b_q, b_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic rdy_q, rdy_d, take, cap, cnt_zero;
  assign take = state_q == S_IDLE && rdy_q && in_valid;
  assign cap = state_q == S_SETTLE && cnt_zero;
  settle_cnt #(.W(8)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (take),
    .en_i       (state_q == S_SETTLE),
    .load_val_i (8'(SETTLE - 1)),
    .zero_o     (cnt_zero)
  );
  // clear is applied before the capture add so a colliding clear keeps only the new product
  always_comb begin
    state_d = take ? S_SETTLE : cap ? S_DONE : (state_q == S_DONE && out_ready) ? S_IDLE : state_q;
    a_d = take ? a_in : a_q;
    b_d = take ? b_in : b_q;
    prod_d = cap ? mpy_p : prod_q;
    acc_d = (acc_clr ? '0 : acc_q) + (cap ? ACCW'(mpy_p) : '0);
    rdy_d = state_d == S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      prod_q <= '0;
      acc_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      prod_q <= prod_d;
      acc_q <= acc_d;
      rdy_q <= rdy_d;
    end
  assign in_ready = rdy_q;
  assign out_valid = state_q == S_DONE;
  assign mpy_a = a_q;
  assign mpy_b = b_q;
  assign prod = prod_q;
  assign acc = acc_q;
endmodule

// File: tb/tb_mpy_ctrl.sv
// tb_mpy_ctrl: directed test-plan cases plus randomized traffic against a timeline model
module tb_mpy_ctrl;
  localparam int S = 12;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, acc_clr = 1'b0;
  logic [3:0] a_in = '0, b_in = '0;
  logic in_ready, out_valid;
  logic [3:0] mpy_a, mpy_b;
  logic [7:0] mpy_p, prod;
  logic [11:0] acc;
  int total = 0, bad = 0;

  always #5 clk = ~clk;
  assign mpy_p = 8'(mpy_a) * 8'(mpy_b);

  mpy_ctrl #(.SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .mpy_a(mpy_a), .mpy_b(mpy_b), .mpy_p(mpy_p),
    .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .acc(acc), .acc_clr(acc_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted pair is captured exactly S edges after its handshake and presented until out_ready
  int cyc = 0, m_issue = 0, m_a = 0, m_b = 0, m_prod = 0, m_acc = 0;
  bit m_rdy = 0, m_busy = 0, m_pres = 0, m_cap = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_issue = 0; m_a = 0; m_b = 0; m_prod = 0; m_acc = 0;
      m_rdy = 0; m_busy = 0; m_pres = 0;
    end else begin
      cyc++;
      m_cap = m_busy && cyc == m_issue + S;
      if (m_pres && out_ready) m_pres = 0;
      else if (m_rdy && in_valid) begin
        m_busy = 1; m_issue = cyc; m_a = int'(a_in); m_b = int'(b_in);
      end
      m_acc = ((acc_clr ? 0 : m_acc) + (m_cap ? m_a * m_b : 0)) % 4096;
      if (m_cap) begin m_prod = m_a * m_b; m_busy = 0; m_pres = 1; end
      m_rdy = !m_busy && !m_pres;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_prod", prod, 0);
      chk("rst_acc", acc, 0);
      chk("rst_operands", {mpy_a, mpy_b}, 0);
    end else begin
      chk("cmp_in_ready", in_ready, m_rdy);
      chk("cmp_out_valid", out_valid, m_pres);
      chk("cmp_mpy_a", mpy_a, m_a);
      chk("cmp_mpy_b", mpy_b, m_b);
      chk("cmp_prod", prod, m_prod);
      chk("cmp_acc", acc, m_acc);
    end
  end

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    while (!in_ready && n < 4 * S) begin @(negedge clk); n++; end
    chk("issue_timeout", n < 4 * S, 1);
    in_valid = 1; a_in = a; b_in = b;
    @(negedge clk);
    in_valid = 0;
    chk("accepted", in_ready, 0);
  endtask

  task automatic op(input logic [3:0] a, input logic [3:0] b, input int p, input int ac, input bit clr);
    int lat = 0;
    issue(a, b);
    while (!out_valid && lat < 4 * S) begin
      acc_clr = clr && lat == S - 1;
      @(negedge clk); lat++;
    end
    acc_clr = 0;
    chk("latency", lat, S);
    chk("prod", prod, p);
    chk("acc", acc, ac);
    if (out_ready) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("init_in_ready", in_ready, 0);
    chk("init_acc", acc, 0);
    #2 rst_n = 1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    op(4'd3, 4'd5, 15, 15, 0);

    do_reset();
    for (int i = 1; i <= 19; i++) op(4'd15, 4'd15, 225, (225 * i) % 4096, 0);
    chk("wrap_acc", acc, 179);
    chk("model_wrap", m_acc, 179);

    do_reset();
    out_ready = 0;
    op(4'd7, 4'd9, 63, 63, 0);
    in_valid = 1; a_in = 4'd1; b_in = 4'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_prod", prod, 63);
      chk("stall_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("release_ready", in_ready, 1);
    chk("release_valid", out_valid, 0);
    chk("stall_not_taken", {mpy_a, mpy_b}, {4'd7, 4'd9});
    in_valid = 0;

    do_reset();
    op(4'd10, 4'd10, 100, 100, 0);
    op(4'd2, 4'd6, 12, 12, 1);

    issue(4'd5, 4'd5);
    repeat (3) @(negedge clk);
    #2 rst_n = 0;
    #1 chk("abort_zero", {in_ready, out_valid, mpy_a, mpy_b, prod, acc}, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_valid", out_valid, 0);
    #2 rst_n = 1;
    @(negedge clk);
    op(4'd1, 4'd1, 1, 1, 0);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      a_in = 4'($urandom);
      b_in = 4'($urandom);
      out_ready = $urandom_range(0, 4) != 0;
      acc_clr = $urandom_range(0, 15) == 0;
    end
    @(negedge clk);
    in_valid = 0; acc_clr = 0; out_ready = 1;
    repeat (2 * S + 4) @(negedge clk);
    chk("drain_idle", in_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mpy_ctrl.md
# mpy_ctrl

Operand sequencer and result capture stage that sits directly upstream and downstream of the 4-bit unsigned array multiplier `MPY`. It accepts operand pairs over a valid/ready handshake and drives them onto `MPY`. It holds them stable until the multiplier's registered ripple chain has settled, then captures the 8-bit product. It presents the product, plus a running 12-bit accumulation, over a second valid/ready handshake.

## Interface
- `SETTLE`, default 12: number of cycles operands are held before `mpy_p` is sampled. Legal range is 1–255, and 12 covers the full carry-ripple depth of `MPY`.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `in_valid`, in, 1: operand pair valid.
- `in_ready`, out, 1: block can accept an operand pair.
- `a_in`, in, 4: multiplicand, unsigned.
- `b_in`, in, 4: multiplier, unsigned.
- `mpy_a`, out, 4: registered operand to `MPY.a`.
- `mpy_b`, out, 4: registered operand to `MPY.b`.
- `mpy_p`, in, 8: product from `MPY.p`.
- `out_valid`, out, 1: `prod` and `acc` are valid.
- `out_ready`, in, 1: consumer accepts the result.
- `prod`, out, 8: captured product.
- `acc`, out, 12: running sum of captured products, modulo 4096.
- `acc_clr`, in, 1: synchronous clear of `acc`.

## Operation
- The FSM has three states: IDLE, SETTLE and DONE. There is one operation in flight at a time.
- **IDLE**
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid`&`in_ready`: latch `a_in`/`b_in` into `mpy_a`/`mpy_b`, load `cnt`=SETTLE-1, and go to SETTLE.
- **SETTLE**
  - `in_ready`=0, and `mpy_a`/`mpy_b` are held constant.
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0, load `prod`←`mpy_p` and `acc`←`acc`+`mpy_p` (zero-extended, wrapping at 12 bits), then go to DONE.
- **DONE**
  - `out_valid`=1, and `prod`/`acc` are held.
  - On `out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored; the upstream side must hold its data until `in_ready`.
- `acc_clr` is honoured in any state.
  - When it coincides with a capture, `acc`←`mpy_p`: the clear applies first, then the add.
  - In DONE, `acc_clr` changes the presented `acc` on the next cycle while `out_valid` stays high.
- `mpy_a`/`mpy_b` keep their last operands after DONE, with no toggling while idle.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0 and 1 on the first cycle after release. All of `out_valid`, `mpy_a`, `mpy_b`, `prod`, `acc` and `cnt` reset to 0, and state resets to IDLE.
- An input handshake at edge E0 gives `mpy_a`/`mpy_b` valid after E0.
- Capture happens at edge E0+SETTLE, and `out_valid` rises after E0+SETTLE.
- Latency from input handshake to `out_valid` is SETTLE cycles.
- Minimum issue interval is SETTLE+2 cycles: one IDLE cycle, SETTLE cycles, and a DONE cycle with `out_ready` high.
- With SETTLE=1, capture happens on the first edge in SETTLE.
- A reset assertion mid-operation aborts the operation immediately.
  - No `out_valid` pulse is produced, and `acc` is lost.
  - The first post-reset handshake behaves as from a fresh start.
- `out_ready` held high before DONE has no effect. The result is still presented for at least one cycle.

## Structure
- Package `mpy_pkg` holds:
  - the state enum (IDLE, SETTLE, DONE);
  - the constants OPW=4, PW=8 and ACCW=12;
  - the default SETTLE.
- One sub-module, `settle_cnt`, is a loadable down-counter with load, enable and zero-flag. The FSM and datapath stay in `mpy_ctrl`.
- `MPY` is instantiated beside `mpy_ctrl` at the level above, not inside it.

## Test plan
- **Basic product:** after reset, send a=3, b=5 → `out_valid` exactly SETTLE cycles after the handshake, with `prod`=15 and `acc`=15.
- **Max operands and accumulation:** send 15×15 four times with `out_ready`=1 → `prod`=225 each time, and `acc` = 225, 450, 675, 900.
- **Accumulator wrap:** send 19 products of 15×15 (sum 4275) → `acc`=179, the sum modulo 4096.
- **Output backpressure:** 7×9 with `out_ready`=0 for 10 cycles → `out_valid`, `prod`=63 and `in_ready`=0 are held throughout. New `in_valid` during the stall is not accepted. Release `out_ready`, and `in_ready` rises next cycle.
- **Clear collision:** pulse `acc_clr` on the capture edge of 2×6 with prior `acc`=100 → `acc`=12.
- **Reset mid-operation:** assert `rst_n`=0 in the 4th SETTLE cycle → all outputs 0 and no `out_valid`. After release, 1×1 gives `prod`=1 and `acc`=1.
